wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline write-back (WB stage result) and a long-latency side unit (multi-cycle mul/div or uncached load completion).
- Side results are buffered in a small FIFO and written into free WB slots.
- A starvation counter forces a one-cycle pipeline bubble when needed.
- Sits between the WB stage and the register file in ID; also supplies the delayed forwarding copy to EX and a hazard flag to ID.

---
 rtl/wb_port_arbiter_pkg.sv | 14 +
 rtl/wb_side_fifo.sv | 76 +++++++
 rtl/wb_port_arbiter.sv | 118 +++++++++++
 tb/tb_wb_port_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_ADR_W = 5;
    localparam int unsigned XLEN      = 32;

    localparam logic [REG_ADR_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_ADR_W-1:0] wadr;
        logic [XLEN-1:0]      wdata;
    } side_entry_t;

endpackage

// File: rtl/wb_side_fifo.sv
// Side-result FIFO with per-entry destination compare for ID hazard detection.
module wb_side_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  side_entry_t                push_data_i,
    input  logic                       pop_i,
    input  logic [REG_ADR_W-1:0]       rs1_adr_i,
    input  logic [REG_ADR_W-1:0]       rs2_adr_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output side_entry_t                head_o,
    output logic                       hit_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    side_entry_t         mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PtrW-1:0] offset;
        hit_o  = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PtrW'(i) - rd_ptr_q;
            if ({1'b0, offset} < cnt_q) begin
                if ((mem_q[i].wadr == rs1_adr_i && rs1_adr_i != REG_X0) ||
                    (mem_q[i].wadr == rs2_adr_i && rs2_adr_i != REG_X0)) begin
                    hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline write-back and a
// buffered long-latency side unit, with a starvation-driven bubble request.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rst_pipe,
    input  logic                   pipe_we_wb,
    input  logic [REG_ADR_W-1:0]   pipe_wadr_wb,
    input  logic [XLEN-1:0]        pipe_wdata_wb,
    input  logic                   side_valid,
    output logic                   side_ready,
    input  logic [REG_ADR_W-1:0]   side_wadr,
    input  logic [XLEN-1:0]        side_wdata,
    input  logic [REG_ADR_W-1:0]   rs1_adr_id,
    input  logic [REG_ADR_W-1:0]   rs2_adr_id,
    output logic                   side_hazard,
    output logic                   stall_req,
    output logic                   rf_we,
    output logic [REG_ADR_W-1:0]   rf_wadr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [XLEN-1:0]        rf_wdata_d1,
    output logic [REG_ADR_W-1:0]   rf_wadr_d1,
    output logic                   rf_we_d1,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam int unsigned StarveW = $clog2(STARVE_LIM) + 1;

    logic        fifo_full, fifo_empty, fifo_push, fifo_pop, pipe_win;
    side_entry_t fifo_head, push_data;

    logic [StarveW-1:0] starve_q, starve_d;
    logic               stall_q, stall_d;

    assign side_ready = ~fifo_full;
    // Writes to x0 complete the handshake but are never buffered.
    assign fifo_push  = side_valid & side_ready & (side_wadr != REG_X0);
    assign push_data  = '{wadr: side_wadr, wdata: side_wdata};
    assign pipe_win   = pipe_we_wb & (pipe_wadr_wb != REG_X0);

    wb_side_fifo #(
        .DEPTH (DEPTH)
    ) u_side_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .rs1_adr_i   (rs1_adr_id),
        .rs2_adr_i   (rs2_adr_id),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .cnt_o       (fifo_cnt),
        .head_o      (fifo_head),
        .hit_o       (side_hazard)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_wadr  = REG_X0;
        rf_wdata = '0;
        fifo_pop = 1'b0;
        if (pipe_win) begin
            rf_we    = 1'b1;
            rf_wadr  = pipe_wadr_wb;
            rf_wdata = pipe_wdata_wb;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            rf_we    = 1'b1;
            rf_wadr  = fifo_head.wadr;
            rf_wdata = fifo_head.wdata;
        end
    end

    // Reaching the last else means the FIFO is non-empty and the pipeline won.
    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (rst_pipe || fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q == StarveW'(STARVE_LIM - 1)) begin
            starve_d = '0;
            stall_d  = 1'b1;
        end else begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q    <= '0;
            stall_q     <= 1'b0;
            rf_we_d1    <= 1'b0;
            rf_wadr_d1  <= '0;
            rf_wdata_d1 <= '0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
            if (rst_pipe) begin
                rf_we_d1    <= 1'b0;
                rf_wadr_d1  <= '0;
                rf_wdata_d1 <= '0;
            end else begin
                rf_we_d1    <= rf_we;
                rf_wadr_d1  <= rf_wadr;
                rf_wdata_d1 <= rf_wdata;
            end
        end
    end

    assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter (DEPTH=2, STARVE_LIM=4).
module tb_wb_port_arbiter;

    typedef struct {
        logic        pwe;
        logic [4:0]  padr;
        logic [31:0] pdat;
        logic        sv;
        logic [4:0]  sadr;
        logic [31:0] sdat;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rp;
        logic        rdy;
        logic        haz;
        logic        stl;
        logic        we;
        logic [4:0]  wadr;
        logic [31:0] wdata;
        logic        we1;
        logic [4:0]  wadr1;
        logic [31:0] wdata1;
        logic [1:0]  cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_pipe = 1'b0;
    logic        pipe_we_wb = 1'b0;
    logic [4:0]  pipe_wadr_wb = '0;
    logic [31:0] pipe_wdata_wb = '0;
    logic        side_valid = 1'b0;
    logic [4:0]  side_wadr = '0;
    logic [31:0] side_wdata = '0;
    logic [4:0]  rs1_adr_id = '0;
    logic [4:0]  rs2_adr_id = '0;
    logic        side_ready, side_hazard, stall_req, rf_we, rf_we_d1;
    logic [4:0]  rf_wadr, rf_wadr_d1;
    logic [31:0] rf_wdata, rf_wdata_d1;
    logic [1:0]  fifo_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];
    vec_t exp_rst;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DEPTH      (2),
        .STARVE_LIM (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rst_pipe      (rst_pipe),
        .pipe_we_wb    (pipe_we_wb),
        .pipe_wadr_wb  (pipe_wadr_wb),
        .pipe_wdata_wb (pipe_wdata_wb),
        .side_valid    (side_valid),
        .side_ready    (side_ready),
        .side_wadr     (side_wadr),
        .side_wdata    (side_wdata),
        .rs1_adr_id    (rs1_adr_id),
        .rs2_adr_id    (rs2_adr_id),
        .side_hazard   (side_hazard),
        .stall_req     (stall_req),
        .rf_we         (rf_we),
        .rf_wadr       (rf_wadr),
        .rf_wdata      (rf_wdata),
        .rf_wdata_d1   (rf_wdata_d1),
        .rf_wadr_d1    (rf_wadr_d1),
        .rf_we_d1      (rf_we_d1),
        .fifo_cnt      (fifo_cnt)
    );

    function automatic vec_t mk(
        input logic pwe, input logic [4:0] padr, input logic [31:0] pdat,
        input logic sv, input logic [4:0] sadr, input logic [31:0] sdat,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic rp,
        input logic rdy, input logic haz, input logic stl,
        input logic we, input logic [4:0] wadr, input logic [31:0] wdata,
        input logic we1, input logic [4:0] wadr1, input logic [31:0] wdata1,
        input logic [1:0] cnt);
        vec_t v;
        v.pwe = pwe; v.padr = padr; v.pdat = pdat;
        v.sv = sv; v.sadr = sadr; v.sdat = sdat;
        v.rs1 = rs1; v.rs2 = rs2; v.rp = rp;
        v.rdy = rdy; v.haz = haz; v.stl = stl;
        v.we = we; v.wadr = wadr; v.wdata = wdata;
        v.we1 = we1; v.wadr1 = wadr1; v.wdata1 = wdata1; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, ".side_ready"},  32'(side_ready),  32'(v.rdy));
        chk({tag, ".side_hazard"}, 32'(side_hazard), 32'(v.haz));
        chk({tag, ".stall_req"},   32'(stall_req),   32'(v.stl));
        chk({tag, ".rf_we"},       32'(rf_we),       32'(v.we));
        chk({tag, ".rf_wadr"},     32'(rf_wadr),     32'(v.wadr));
        chk({tag, ".rf_wdata"},    rf_wdata,         v.wdata);
        chk({tag, ".rf_we_d1"},    32'(rf_we_d1),    32'(v.we1));
        chk({tag, ".rf_wadr_d1"},  32'(rf_wadr_d1),  32'(v.wadr1));
        chk({tag, ".rf_wdata_d1"}, rf_wdata_d1,      v.wdata1);
        chk({tag, ".fifo_cnt"},    32'(fifo_cnt),    32'(v.cnt));
    endtask

    task automatic drive(input vec_t v);
        pipe_we_wb = v.pwe; pipe_wadr_wb = v.padr; pipe_wdata_wb = v.pdat;
        side_valid = v.sv;  side_wadr = v.sadr;    side_wdata = v.sdat;
        rs1_adr_id = v.rs1; rs2_adr_id = v.rs2;    rst_pipe = v.rp;
    endtask

    initial begin
        exp_rst = mk(0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,0,0, 0,0,0, 0);

        // pipe we/adr/data | side v/adr/data | rs1 rs2 rst_pipe || rdy haz stall | we adr data | d1 | cnt
        // Simple side write with idle pipeline
        vecs.push_back(mk(0,0,0,        1,5,32'h1234, 0,0,0,  1,0,0, 0,0,0,           0,0,0,           0));
        vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,  1,0,0, 1,5,32'h1234,    0,0,0,           1));
        vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,  1,0,0, 0,0,0,           1,5,32'h1234,    0));
        // Fill while pipeline owns the port; third push held off, ordered drain
        vecs.push_back(mk(1,1,32'hA1,   1,6,32'h66,   0,0,0,  1,0,0, 1,1,32'hA1,      0,0,0,           0));
        vecs.push_back(mk(1,2,32'hA2,   1,7,32'h77,   0,0,0,  1,0,0, 1,2,32'hA2,      1,1,32'hA1,      1));
        vecs.push_back(mk(1,3,32'hA3,   1,8,32'h88,   0,0,0,  0,0,0, 1,3,32'hA3,      1,2,32'hA2,      2));
        vecs.push_back(mk(0,0,0,        1,8,32'h88,   0,0,0,  0,0,0, 1,6,32'h66,      1,3,32'hA3,      2));
        vecs.push_back(mk(0,0,0,        1,8,32'h88,   0,0,0,  1,0,0, 1,7,32'h77,      1,6,32'h66,      1));
        // Starvation: x8 held for 4 denied cycles
        vecs.push_back(mk(1,4,32'hB0,   0,0,0,        0,0,0,  1,0,0, 1,4,32'hB0,      1,7,32'h77,      1));
        vecs.push_back(mk(1,4,32'hB1,   0,0,0,        0,0,0,  1,0,0, 1,4,32'hB1,      1,4,32'hB0,      1));
        vecs.push_back(mk(1,4,32'hB2,   0,0,0,        0,0,0,  1,0,0, 1,4,32'hB2,      1,4,32'hB1,      1));
        vecs.push_back(mk(1,4,32'hB3,   0,0,0,        0,0,0,  1,0,0, 1,4,32'hB3,      1,4,32'hB2,      1));
        vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,  1,0,1, 1,8,32'h88,      1,4,32'hB3,      1));
        vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,  1,0,0, 0,0,0,           1,8,32'h88,      0));
        // x0 handling on both sources
        vecs.push_back(mk(0,0,0,        1,9,32'h99,   0,0,0,  1,0,0, 0,0,0,           0,0,0,           0));
        vecs.push_back(mk(1,0,32'hDEAD, 1,0,32'h55,   0,0,0,  1,0,0, 1,9,32'h99,      0,0,0,           1));
        vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,  1,0,0, 0,0,0,           1,9,32'h99,      0));
        // Hazard on rs1, no bypass, held through the pop cycle
        vecs.push_back(mk(1,1,32'hC0,   1,10,32'hAA,  10,0,0, 1,0,0, 1,1,32'hC0,      0,0,0,           0));
        vecs.push_back(mk(1,1,32'hC1,   0,0,0,        10,0,0, 1,1,0, 1,1,32'hC1,      1,1,32'hC0,      1));
        vecs.push_back(mk(0,0,0,        0,0,0,        10,0,0, 1,1,0, 1,10,32'hAA,     1,1,32'hC1,      1));
        vecs.push_back(mk(0,0,0,        0,0,0,        10,0,0, 1,0,0, 0,0,0,           1,10,32'hAA,     0));
        // rst_pipe at counter 2 restarts starvation count, FIFO kept
        vecs.push_back(mk(1,2,32'hD0,   1,11,32'hBB,  0,0,0,  1,0,0, 1,2,32'hD0,      0,0,0,           0));
        vecs.push_back(mk(1,2,32'hD1,   0,0,0,        0,11,0, 1,1,0, 1,2,32'hD1,      1,2,32'hD0,      1));
        vecs.push_back(mk(1,2,32'hD2,   0,0,0,        0,0,0,  1,0,0, 1,2,32'hD2,      1,2,32'hD1,      1));
        vecs.push_back(mk(1,2,32'hD3,   0,0,0,        0,0,1,  1,0,0, 1,2,32'hD3,      1,2,32'hD2,      1));
        vecs.push_back(mk(1,2,32'hD4,   0,0,0,        0,0,0,  1,0,0, 1,2,32'hD4,      0,0,0,           1));
        vecs.push_back(mk(1,2,32'hD5,   0,0,0,        0,0,0,  1,0,0, 1,2,32'hD5,      1,2,32'hD4,      1));
        vecs.push_back(mk(1,2,32'hD6,   0,0,0,        0,0,0,  1,0,0, 1,2,32'hD6,      1,2,32'hD5,      1));
        vecs.push_back(mk(1,2,32'hD7,   0,0,0,        0,0,0,  1,0,0, 1,2,32'hD7,      1,2,32'hD6,      1));
        vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,  1,0,1, 1,11,32'hBB,     1,2,32'hD7,      1));
        vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,  1,0,0, 0,0,0,           1,11,32'hBB,     0));
        // Start a drain that gets cut by async reset below
        vecs.push_back(mk(0,0,0,        1,12,32'hCC,  0,0,0,  1,0,0, 0,0,0,           0,0,0,           0));
        vecs.push_back(mk(0,0,0,        1,13,32'hDD,  0,0,0,  1,0,0, 1,12,32'hCC,     0,0,0,           1));
        vecs.push_back(mk(0,0,0,        0,0,0,        13,0,0, 1,1,0, 1,13,32'hDD,     1,12,32'hCC,     1));

        #12;
        check_all("reset", exp_rst);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_all($sformatf("r%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-drain: outputs return to reset values immediately
        rst_n = 1'b0;
        #1;
        check_all("async_rst", exp_rst);
        @(negedge clk);
        drive(exp_rst);
        #1;
        check_all("rst_held", exp_rst);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_all("post_rst", exp_rst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
